// File: rtl/alu_pkg.sv
// Shared widths, FSM encoding and opSel names for the ALU datapath.
// Imported by the sequencer, the ALU and the benches.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int RES_W  = 8;
    localparam int CNT_W  = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_A    = 3'd0;
    localparam state_t S_B    = 3'd1;
    localparam state_t S_OP   = 3'd2;
    localparam state_t S_EXEC = 3'd3;
    localparam state_t S_HOLD = 3'd4;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_MUL = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL = 3'd6;
    localparam logic [OP_W-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_op_sequencer.sv
// Collects an A/B/opcode beat stream, feeds the combinational ALU from
// registers, captures its result after one settle cycle and hands it on.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int P_DATA_W = DATA_W,
    parameter int P_OP_W   = OP_W,
    parameter int P_RES_W  = RES_W,
    parameter int P_CNT_W  = CNT_W
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [P_DATA_W-1:0] in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                abort_i,
    output logic [P_DATA_W-1:0] alu_A_o,
    output logic [P_DATA_W-1:0] alu_B_o,
    output logic [P_OP_W-1:0]   alu_opSel_o,
    input  logic [P_RES_W-1:0]  alu_result_i,
    output logic [P_RES_W-1:0]  res_data_o,
    output logic [P_OP_W-1:0]   res_op_o,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic                busy_o,
    output logic [P_CNT_W-1:0]  tx_count_o
);

    if (P_RES_W != 2 * P_DATA_W) begin : g_bad_cfg
        $error("alu_op_sequencer: P_RES_W must equal 2*P_DATA_W");
    end

    state_t              r_state;
    logic [P_DATA_W-1:0] r_a;
    logic [P_DATA_W-1:0] r_b;
    logic [P_OP_W-1:0]   r_op;
    logic [P_RES_W-1:0]  r_res;
    logic [P_OP_W-1:0]   r_res_op;
    logic                r_res_valid;
    logic [P_CNT_W-1:0]  r_tx;

    logic w_ready;
    logic w_busy;
    logic w_accept;
    logic w_res_hs;

    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        unique case (1'b1)
            (r_state == S_A),
            (r_state == S_B),
            (r_state == S_OP):   w_ready = 1'b1;
            (r_state == S_EXEC),
            (r_state == S_HOLD): w_busy  = 1'b1;
            default:             w_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid_i && w_ready;
    assign w_res_hs = r_res_valid && res_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_A;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_res       <= '0;
            r_res_op    <= '0;
            r_res_valid <= 1'b0;
            r_tx        <= '0;
        end else if (abort_i) begin
            // Abort outranks both beat acceptance and the result handshake.
            r_state     <= S_A;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_A: if (w_accept) begin
                    r_a     <= in_data_i;
                    r_state <= S_B;
                end
                S_B: if (w_accept) begin
                    r_b     <= in_data_i;
                    r_state <= S_OP;
                end
                S_OP: if (w_accept) begin
                    r_op    <= in_data_i[P_OP_W-1:0];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_res       <= alu_result_i;
                    r_res_op    <= r_op;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: if (w_res_hs) begin
                    r_res_valid <= 1'b0;
                    r_tx        <= r_tx + P_CNT_W'(1);
                    r_state     <= S_A;
                end
                default: r_state <= S_A;
            endcase
        end
    end

    assign in_ready_o  = w_ready;
    assign busy_o      = w_busy;
    assign alu_A_o     = r_a;
    assign alu_B_o     = r_b;
    assign alu_opSel_o = r_op;
    assign res_data_o  = r_res;
    assign res_op_o    = r_res_op;
    assign res_valid_o = r_res_valid;
    assign tx_count_o  = r_tx;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with an ALU stub that
// returns {alu_B_o, alu_A_o} so results are easy to predict.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              abort;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [RES_W-1:0]  alu_res;
    logic [RES_W-1:0]  res_data;
    logic [OP_W-1:0]   res_op;
    logic              res_valid;
    logic              res_ready;
    logic              busy;
    logic [CNT_W-1:0]  tx_count;

    int n_tests;
    int n_fail;
    logic [CNT_W-1:0] exp_tx;

    alu_op_sequencer dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .abort_i      (abort),
        .alu_A_o      (alu_a),
        .alu_B_o      (alu_b),
        .alu_opSel_o  (alu_op),
        .alu_result_i (alu_res),
        .res_data_o   (res_data),
        .res_op_o     (res_op),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .busy_o       (busy),
        .tx_count_o   (tx_count)
    );

    assign alu_res = {alu_b, alu_a};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] op, input logic [7:0] er,
                           input logic [2:0] eop);
        in_valid = 1'b1;
        in_data  = a;
        tick();
        in_data = b;
        tick();
        in_data = op;
        tick();
        in_valid = 1'b0;
        check("txn_exec_busy", busy, 1);
        check("txn_exec_rv", res_valid, 0);
        res_ready = 1'b1;
        tick();
        check("txn_rv", res_valid, 1);
        check("txn_data", res_data, er);
        check("txn_op", res_op, eop);
        tick();
        res_ready = 1'b0;
        exp_tx = exp_tx + 8'd1;
        check("txn_rv_low", res_valid, 0);
        check("txn_tx", tx_count, exp_tx);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        exp_tx    = 8'd0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        res_ready = 1'b0;
        #1;
        check("rst_a", alu_a, 0);
        check("rst_rv", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_tx", tx_count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", in_ready, 1);

        // Case 1
        in_valid = 1'b1;
        in_data  = 4'h3;
        tick();
        check("c1_a", alu_a, 4'h3);
        in_data = 4'h5;
        tick();
        check("c1_b", alu_b, 4'h5);
        in_data = 4'h2;
        tick();
        in_valid = 1'b0;
        check("c1_op", alu_op, 3'd2);
        check("c1_busy", busy, 1);
        check("c1_ready", in_ready, 0);
        tick();
        check("c1_rv", res_valid, 1);
        check("c1_data", res_data, 8'h53);
        check("c1_rop", res_op, 3'd2);
        check("c1_tx0", tx_count, 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("c1_rv_low", res_valid, 0);
        check("c1_tx1", tx_count, 1);
        check("c1_idle", busy, 0);
        exp_tx = 8'd1;

        // Case 2
        in_valid = 1'b1;
        in_data  = 4'h3;
        tick();
        in_data = 4'h5;
        tick();
        in_data = 4'h2;
        tick();
        tick();
        in_data = 4'h9;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("c2_rv", res_valid, 1);
            check("c2_data", res_data, 8'h53);
            check("c2_ready", in_ready, 0);
            check("c2_a", alu_a, 4'h3);
            check("c2_tx", tx_count, 1);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("c2_tx2", tx_count, 2);
        tick();
        check("c2_tx_once", tx_count, 2);
        exp_tx = 8'd2;

        // Case 3
        in_valid = 1'b1; in_data = 4'hF; tick();
        check("c3_a", alu_a, 4'hF);
        in_valid = 1'b0; in_data = 4'h1; tick();
        in_valid = 1'b0; in_data = 4'h2; tick();
        check("c3_b_hold", alu_b, 4'h5);
        in_valid = 1'b1; in_data = 4'hE; tick();
        check("c3_b", alu_b, 4'hE);
        in_valid = 1'b0; in_data = 4'h3; tick();
        check("c3_op_hold", alu_op, 3'd2);
        in_valid = 1'b1; in_data = 4'hF; tick();
        in_valid = 1'b0;
        check("c3_op", alu_op, 3'd7);
        tick();
        check("c3_data", res_data, 8'hEF);
        check("c3_rop", res_op, 3'd7);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("c3_tx", tx_count, 3);
        exp_tx = 8'd3;

        // Case 4
        in_valid = 1'b1; in_data = 4'h1; tick();
        in_data = 4'h2; tick();
        in_data = 4'h6;
        abort   = 1'b1;
        tick();
        abort = 1'b0;
        check("c4_a0", alu_a, 0);
        check("c4_b0", alu_b, 0);
        check("c4_op0", alu_op, 0);
        check("c4_busy", busy, 0);
        check("c4_ready", in_ready, 1);
        check("c4_tx", tx_count, 3);
        in_data = 4'h4; tick();
        check("c4_restart_a", alu_a, 4'h4);
        check("c4_restart_b", alu_b, 0);
        in_data = 4'h1; tick();
        in_data = 4'h3; tick();
        in_valid = 1'b0;
        tick();
        check("c4_hold_rv", res_valid, 1);
        check("c4_hold_data", res_data, 8'h14);
        abort     = 1'b1;
        res_ready = 1'b1;
        tick();
        abort     = 1'b0;
        res_ready = 1'b0;
        check("c4_ab_rv", res_valid, 0);
        check("c4_ab_tx", tx_count, 3);
        check("c4_ab_a", alu_a, 0);
        check("c4_ab_op", alu_op, 0);
        check("c4_ab_busy", busy, 0);

        // Case 5
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            run_txn(v[3:0], v[7:4], {1'b0, v[2:0]}, v, v[2:0]);
        end
        check("c5_wrap", tx_count, 3);

        // Case 6
        in_valid = 1'b1; in_data = 4'h9; tick();
        in_data = 4'h8;
        #2;
        rst_n = 1'b0;
        #1;
        check("c6_a", alu_a, 0);
        check("c6_tx", tx_count, 0);
        check("c6_rdata", res_data, 0);
        check("c6_busy", busy, 0);
        check("c6_ready", in_ready, 1);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_tx = 8'd0;
        tick();
        run_txn(4'h6, 4'hA, 4'h1, 8'hA6, 3'd1);
        check("c6_tx1", tx_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream feeder and result capture for the team's combinational 4-bit ALU (A_i, B_i, opSel -> 8-bit o_alu).
- Accepts a 3-beat operand stream (A, B, opcode) over valid/ready and drives registered, stable operands into the ALU.
- Captures the ALU result after one settle cycle, then presents it downstream over valid/ready with an opcode tag and a transaction counter.

Parameters:
- DATA_W, 4, operand width; drives ALU A_i/B_i.
- OP_W, 3, opcode width; drives ALU opSel.
- RES_W, 8, result width; must equal 2*DATA_W.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- in_data_i  in  DATA_W  operand/opcode beat.
- in_valid_i  in  1  beat valid.
- in_ready_o  out  1  block can accept a beat.
- abort_i  in  1  synchronous transaction abort.
- alu_A_o  out  DATA_W  to ALU A_i.
- alu_B_o  out  DATA_W  to ALU B_i.
- alu_opSel_o  out  OP_W  to ALU opSel.
- alu_result_i  in  RES_W  from ALU o_alu.
- res_data_o  out  RES_W  captured result.
- res_op_o  out  OP_W  opcode that produced res_data_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  downstream accepts result.
- busy_o  out  1  high in EXEC/HOLD.
- tx_count_o  out  CNT_W  completed result handshakes.

Behaviour:
- Clock is clk_i. Reset rst_n_i is asynchronous and active-low: assertion immediately forces reset values; release is sampled on the next rising edge.
- Reset values:
  - state = S_A.
  - alu_A_o, alu_B_o, alu_opSel_o, res_data_o, res_op_o, tx_count_o = 0.
  - res_valid_o = 0, busy_o = 0.
  - in_ready_o = 1 once reset is released (state S_A).
- States: S_A, S_B, S_OP, S_EXEC, S_HOLD.
- in_ready_o = 1 in S_A, S_B, S_OP; 0 in S_EXEC and S_HOLD. It is decoded combinationally from state only, with no dependence on in_valid_i.
- A beat is accepted on an edge where in_valid_i && in_ready_o.
- S_A: on accept, alu_A_o <= in_data_i, go to S_B.
- S_B: on accept, alu_B_o <= in_data_i, go to S_OP.
- S_OP: on accept, alu_opSel_o <= in_data_i[OP_W-1:0] (upper bits ignored), go to S_EXEC.
- No accept in S_A/S_B/S_OP: hold state and registers. in_valid_i may toggle freely.
- S_EXEC (exactly one cycle):
  - The ALU settles from the registered operands.
  - Next edge: res_data_o <= alu_result_i, res_op_o <= alu_opSel_o, res_valid_o <= 1, go to S_HOLD.
- Latency: opcode accepted at edge k -> res_valid_o rises at edge k+1.
- S_HOLD:
  - res_valid_o, res_data_o and res_op_o are held stable until res_valid_o && res_ready_i.
  - On that handshake: res_valid_o <= 0, tx_count_o <= tx_count_o + 1, go to S_A.
- Back-to-back: minimum 5 cycles per transaction (3 beats + EXEC + HOLD handshake).
- alu_* registers keep their last values after a handshake. They change only when the corresponding beat of the next transaction is accepted.
- tx_count_o is modulo 2^CNT_W: 255 -> 0 with no saturation and no flag.
- res_ready_i is ignored outside S_HOLD. An asserted res_ready_i in S_EXEC does not shorten latency.
- abort_i is synchronous and has the highest priority, in any state:
  - Next edge: state <= S_A, res_valid_o <= 0, alu_A_o/alu_B_o/alu_opSel_o <= 0.
  - tx_count_o is unchanged.
  - A beat presented in the same cycle is not accepted, even though in_ready_o may read 1.
- abort_i and a res handshake in the same cycle: abort wins, and the counter does not increment.
- Reset mid-transaction: immediate return to reset values. Partial operands are discarded.
- RES_W != 2*DATA_W is illegal: generation-time error.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W, OP_W, RES_W defaults.
  - The state typedef/encoding (S_A..S_HOLD, 3-bit).
  - Named opSel constants, also used by the ALU and benches.
- No sub-module: one FSM plus datapath registers. The ALU itself is instantiated beside this block at the parent level (alu_datapath_top), not inside it.

Test Plan:
- Bench stub drives alu_result_i = {alu_B_o, alu_A_o}.
- Case 1: After reset, stream A=3, B=5, op=2 with in_valid_i held high -> alu_A_o=3, alu_B_o=5, alu_opSel_o=2 on consecutive edges; res_valid_o rises one edge after op accept; res_data_o=8'h53, res_op_o=2, busy_o=1 until handshake; tx_count_o 0->1.
- Case 2: res_ready_i held low for 4 cycles in S_HOLD -> res_valid_o stays 1, res_data_o stable at 8'h53, in_ready_o=0; input beats ignored; release -> tx_count_o increments once.
- Case 3: Gaps: in_valid_i toggling 1,0,0,1,0,1 with data F,x,x,E,x,7 and op=7 (only 7 accepted as op) -> alu_A_o=F, alu_B_o=E, alu_opSel_o=7, res_data_o=8'hEF; in_data_i=4'hF for op -> alu_opSel_o=7 (bit 3 dropped).
- Case 4: abort_i pulsed in S_OP, then in S_HOLD with res_ready_i=1 in the same cycle -> state S_A, res_valid_o=0, operands 0, tx_count_o unchanged in both cases.
- Case 5: 256 back-to-back transactions with res_ready_i=1 -> tx_count_o wraps to 0; each result spaced 5 cycles.
- Case 6: rst_n_i asserted mid-S_B, asynchronously between edges -> all outputs read reset values before the next edge; first full transaction after release succeeds.
